// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main memory between the I-cache fill path and the
// D-cache fill/write-back path. One line transaction is in flight at a time:
// a grant latches the winner's command, the command is held on the memory
// port until m_rdy (or timeout), then the owner gets a one-cycle ack.
//
// Ports
//   clk, rst_n            clock (rising edge) / asynchronous active-low reset
//   i_req, i_addr         instruction line read request (held until i_ack)
//   i_ack, i_rdata        one-cycle completion pulse / returned I line
//   d_req, d_we, d_addr,  data request (held until d_ack); d_we=1 write-back
//   d_wdata
//   d_ack, d_rdata        one-cycle completion pulse / returned D line
//   m_re, m_we            memory read / write strobes, held through MEM
//   m_addr, m_wdata       latched memory command
//   m_rdata, m_rdy        memory read line / transaction complete
//   busy                  not IDLE
//   timeout_err           sticky: memory failed to answer within MAX_WAIT
module mem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_re,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rdy,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

    // Last MEM cycle allowed: the counter runs 0..MAX_WAIT-1, so the strobe
    // is up for at most MAX_WAIT cycles.
    localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    logic              own_d_q;     // 1 = D owns the transaction
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              last_d_q;    // last grant went to D
    logic [7:0]        cnt_q;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
    logic              to_q;

    logic grant, grant_d;

    // Next state and arbitration. Under contention D wins unless it won last.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    grant   = 1'b1;
                    grant_d = d_req && (!i_req || !last_d_q);
                    state_d = MEM;
                end
            end
            MEM: begin
                if (m_rdy || cnt_q == CNT_LAST) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            own_d_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            last_d_q  <= 1'b0;
            cnt_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            to_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                own_d_q  <= grant_d;
                addr_q   <= grant_d ? d_addr : i_addr;
                we_q     <= grant_d && d_we;
                wdata_q  <= d_wdata;
                last_d_q <= grant_d;
                cnt_q    <= '0;
            end
            if (state_q == MEM) begin
                if (m_rdy) begin
                    if (!we_q) begin
                        if (own_d_q) d_rdata_q <= m_rdata;
                        else         i_rdata_q <= m_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    to_q <= 1'b1;
                    // Poison the read line so a consumer sees obvious junk.
                    if (!we_q) begin
                        if (own_d_q) d_rdata_q <= '1;
                        else         i_rdata_q <= '1;
                    end
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    // Outputs: decoded from state and latched fields only.
    assign busy        = (state_q != IDLE);
    assign m_re        = (state_q == MEM) && !we_q;
    assign m_we        = (state_q == MEM) && we_q;
    assign m_addr      = addr_q;
    assign m_wdata     = wdata_q;
    assign i_ack       = (state_q == RESP) && !own_d_q;
    assign d_ack       = (state_q == RESP) && own_d_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model:
// the model tracks who is waiting, picks the winner by the alternation rule,
// predicts strobe/ack timing from the chosen memory wait, and keeps the
// expected I/D read lines and sticky timeout flag.
module tb_mem_arbiter;

    localparam int AW = 14;
    localparam int DW = 64;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, d_req, d_we, m_rdy;
    logic [AW-1:0] i_addr, d_addr, m_addr;
    logic [DW-1:0] d_wdata, m_rdata, i_rdata, d_rdata, m_wdata;
    logic          i_ack, d_ack, m_re, m_we, busy, timeout_err;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_rdy(m_rdy),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state
    bit            pi, pd;          // requester currently holding req
    logic [AW-1:0] ia, da;
    logic          dwe;
    logic [DW-1:0] dwd;
    bit            last_d;          // last grant went to D
    logic [DW-1:0] exp_ir, exp_dr;
    bit            exp_to;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic new_i();
        pi = 1; ia = AW'($urandom);
    endtask

    task automatic new_d();
        pd = 1; da = AW'($urandom); dwe = 1'($urandom_range(1)); dwd = rnd64();
    endtask

    // Idle requesters may wiggle their fields freely.
    task automatic drive();
        i_req   = pi;
        i_addr  = pi ? ia : AW'($urandom);
        d_req   = pd;
        d_addr  = pd ? da : AW'($urandom);
        d_we    = pd ? dwe : 1'($urandom_range(1));
        d_wdata = pd ? dwd : rnd64();
    endtask

    task automatic chk_rd(input string tag);
        chk({tag, "_irdata"}, i_rdata, exp_ir);
        chk({tag, "_drdata"}, d_rdata, exp_dr);
        chk({tag, "_to"}, timeout_err, exp_to);
    endtask

    // Called at the falling edge of an IDLE cycle with a request pending.
    // w   : memory wait cycles before m_rdy (-1 = never answers)
    // mode: 0 owner drops after ack, 1 owner re-requests, 2 random
    task automatic txn(input int w, input bit use_rd, input logic [DW-1:0] rdv, input int mode);
        bit od, we, tmo, done;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rd;
        int k;
        od = (pi && pd) ? !last_d : pd;
        last_d = od;
        a  = od ? da : ia;
        we = od && dwe;
        wd = dwd;
        rd = use_rd ? rdv : rnd64();
        @(posedge clk); @(negedge clk);
        k = 0; done = 0; tmo = 0;
        while (!done) begin
            chk("mem_busy", busy, 1);
            chk("mem_re", m_re, !we);
            chk("mem_we", m_we, we);
            chk("mem_addr", m_addr, a);
            if (we) chk("mem_wdata", m_wdata, wd);
            chk("mem_noack", {i_ack, d_ack}, 0);
            if (od && !pi && $urandom_range(3) == 0) new_i();
            if (!od && !pd && $urandom_range(3) == 0) new_d();
            drive();
            m_rdy   = (k == w);
            m_rdata = (k == w) ? rd : rnd64();
            done = (k == w) || (k == MW - 1);
            tmo  = (k != w) && (k == MW - 1);
            @(posedge clk); @(negedge clk);
            k++;
        end
        // RESP: m_rdy here must be ignored
        m_rdy = 1'($urandom_range(1));
        m_rdata = rnd64();
        if (!we) begin
            if (tmo) rd = '1;
            if (od) exp_dr = rd; else exp_ir = rd;
        end
        if (tmo) exp_to = 1;
        chk("resp_iack", i_ack, !od);
        chk("resp_dack", d_ack, od);
        chk("resp_strobes", {m_re, m_we}, 0);
        chk("resp_busy", busy, 1);
        chk_rd("resp");
        @(posedge clk); @(negedge clk);
        m_rdy = 1'($urandom_range(1));
        chk("idle_busy", busy, 0);
        chk("idle_noack", {i_ack, d_ack}, 0);
        chk_rd("idle");
        if (od) pd = 0; else pi = 0;
        if (mode == 1 || (mode == 2 && $urandom_range(1) == 1)) begin
            if (od) new_d(); else new_i();
        end
        drive();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_acks"}, {i_ack, d_ack}, 0);
        chk({tag, "_strobes"}, {m_re, m_we}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_maddr"}, m_addr, 0);
        chk({tag, "_mwdata"}, m_wdata, 0);
        chk_rd(tag);
    endtask

    task automatic model_reset();
        pi = 0; pd = 0; last_d = 0;
        exp_ir = '0; exp_dr = '0; exp_to = 0;
    endtask

    function automatic int rnd_wait();
        if ($urandom_range(9) == 0) return -1;
        if ($urandom_range(3) == 0) return MW - 1;
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        model_reset();
        ia = '0; da = '0; dwe = 0; dwd = '0;
        rst_n = 0; m_rdy = 0; m_rdata = '0;
        drive();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1;

        // 1: I read, zero wait
        pi = 1; ia = 14'h0040; drive();
        txn(0, 1, 64'h1111_2222_3333_4444, 0);

        // 2: D write, three wait cycles
        pd = 1; dwe = 1; da = 14'h3C01; dwd = 64'hDEAD_BEEF_0000_0001; drive();
        txn(3, 0, '0, 0);

        // 6: stray m_rdy while idle with no request
        m_rdy = 1; drive();
        @(posedge clk); @(negedge clk);
        m_rdy = 0;
        chk("stray_busy", busy, 0);
        chk("stray_acks", {i_ack, d_ack}, 0);

        // 4: D read, memory never answers
        pd = 1; dwe = 0; da = AW'($urandom); drive();
        txn(-1, 0, '0, 0);

        // 3: continuous contention, D/I alternation from whatever last won
        new_i(); new_d(); drive();
        repeat (4) txn(0, 0, '0, 1);

        // Random traffic
        for (int n = 0; n < 250; n++) begin
            if (!pi && $urandom_range(2) == 0) new_i();
            if (!pd && $urandom_range(2) == 0) new_d();
            drive();
            if (pi || pd) begin
                txn(rnd_wait(), 0, '0, 2);
            end else begin
                m_rdy = 1'($urandom_range(1));
                @(posedge clk); @(negedge clk);
                m_rdy = 0;
                chk("rnd_idle_busy", busy, 0);
                chk("rnd_idle_acks", {i_ack, d_ack}, 0);
            end
        end
        while (pi || pd) txn(0, 0, '0, 0);

        // 5: reset during MEM of an I read
        pi = 1; ia = AW'($urandom); drive();
        @(posedge clk); @(negedge clk);
        chk("pre_rst_re", m_re, 1);
        rst_n = 0;
        #1;
        model_reset();
        m_rdy = 0; drive();
        chk_zero("async_rst");
        @(posedge clk); @(negedge clk);
        chk_zero("rst_hold");
        rst_n = 1;
        new_i(); new_d(); drive();
        chk("post_rst_lastd", last_d, 0);
        txn(1, 0, '0, 0);   // model expects D to win here

        for (int n = 0; n < 100; n++) begin
            if (!pi && $urandom_range(1) == 0) new_i();
            if (!pd && $urandom_range(1) == 0) new_d();
            drive();
            if (pi || pd) txn(rnd_wait(), 0, '0, 2);
            else begin
                @(posedge clk); @(negedge clk);
                chk("rnd2_idle_busy", busy, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
